// File: rtl/rtc_timekeeper.sv
// BCD time-of-day counter (HH:MM:SS) clocked entirely on clk, advanced by a 1 Hz tick enable
// from an internal prescaler, with validated load, 12/24 h display conversion and minute alarm.
module rtc_timekeeper #(
    parameter int unsigned CLK_HZ = 25_000_000,
    parameter logic [7:0]  RST_H  = 8'h23,
    parameter logic [7:0]  RST_M  = 8'h59,
    parameter logic [7:0]  RST_S  = 8'h59
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        mode_12h,
    input  logic        load,
    input  logic [23:0] load_time,
    input  logic        alarm_en,
    input  logic [15:0] alarm_time,
    output logic [3:0]  cnt_sec1,
    output logic [3:0]  cnt_sec10,
    output logic [3:0]  cnt_min1,
    output logic [3:0]  cnt_min10,
    output logic [3:0]  cnt_hour1,
    output logic [3:0]  cnt_hour10,
    output logic        pm,
    output logic        tick_1hz,
    output logic        alarm_hit,
    output logic        load_err
);

    localparam int unsigned     PS_W  = $clog2(CLK_HZ);
    localparam logic [PS_W-1:0] PS_TC = PS_W'(CLK_HZ - 1);

    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h1;
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } bcd_time_t;

    bcd_time_t       time_q, time_d, time_inc, load_t;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            alarm_hit_q, alarm_hit_d;
    logic            load_err_q, load_err_d;
    logic            load_ok, load_valid, ps_wrap, tick;
    logic [6:0]      hour_bin, disp_bin;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        load_t  = bcd_time_t'(load_time);
        load_ok = (load_t.s1 <= 4'd9) && (load_t.s10 <= 4'd5) &&
                  (load_t.m1 <= 4'd9) && (load_t.m10 <= 4'd5) &&
                  (load_t.h1 <= 4'd9) && (load_t.h10 <= 4'd2) &&
                  !((load_t.h10 == 4'd2) && (load_t.h1 > 4'd3));
        load_valid = load && load_ok;
        ps_wrap    = run && (ps_q == PS_TC);
        // A valid load restarts the second, so it swallows a coincident tick.
        tick       = resetn && ps_wrap && !load_valid;
    end

    // Ripple-carry BCD increment; each stage only moves when all lower stages roll over.
    always_comb begin
        time_inc = time_q;
        if (time_q.s1 != 4'd9) begin
            time_inc.s1 = time_q.s1 + 4'd1;
        end else begin
            time_inc.s1 = 4'd0;
            if (time_q.s10 != 4'd5) begin
                time_inc.s10 = time_q.s10 + 4'd1;
            end else begin
                time_inc.s10 = 4'd0;
                if (time_q.m1 != 4'd9) begin
                    time_inc.m1 = time_q.m1 + 4'd1;
                end else begin
                    time_inc.m1 = 4'd0;
                    if (time_q.m10 != 4'd5) begin
                        time_inc.m10 = time_q.m10 + 4'd1;
                    end else begin
                        time_inc.m10 = 4'd0;
                        if ((time_q.h10 == 4'd2) && (time_q.h1 == 4'd3)) begin
                            time_inc.h10 = 4'd0;
                            time_inc.h1  = 4'd0;
                        end else if (time_q.h1 == 4'd9) begin
                            time_inc.h10 = time_q.h10 + 4'd1;
                            time_inc.h1  = 4'd0;
                        end else begin
                            time_inc.h1  = time_q.h1 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        time_d      = time_q;
        ps_d        = ps_q;
        alarm_hit_d = 1'b0;
        load_err_d  = 1'b0;
        if (load_valid) begin
            time_d = load_t;
            ps_d   = '0;
        end else begin
            load_err_d = load;
            if (run) ps_d = ps_wrap ? '0 : ps_q + PS_W'(1);
            if (tick) begin
                time_d      = time_inc;
                alarm_hit_d = alarm_en && (time_inc == {alarm_time, 8'h00});
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            time_q      <= {RST_H, RST_M, RST_S};
            ps_q        <= '0;
            alarm_hit_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            time_q      <= time_d;
            ps_q        <= ps_d;
            alarm_hit_q <= alarm_hit_d;
            load_err_q  <= load_err_d;
        end
    end

    // Hour display conversion works in binary, then splits back into two BCD digits.
    always_comb begin
        hour_bin = 7'(time_q.h10) * 7'd10 + 7'(time_q.h1);
        pm       = (hour_bin >= 7'd12);
        if (hour_bin == 7'd0)       disp_bin = 7'd12;
        else if (hour_bin > 7'd12)  disp_bin = hour_bin - 7'd12;
        else                        disp_bin = hour_bin;
        cnt_hour10 = time_q.h10;
        cnt_hour1  = time_q.h1;
        if (mode_12h) begin
            if (disp_bin >= 7'd10) begin
                cnt_hour10 = 4'd1;
                cnt_hour1  = 4'(disp_bin - 7'd10);
            end else begin
                cnt_hour10 = 4'd0;
                cnt_hour1  = 4'(disp_bin);
            end
        end
    end

    assign cnt_sec1  = time_q.s1;
    assign cnt_sec10 = time_q.s10;
    assign cnt_min1  = time_q.m1;
    assign cnt_min10 = time_q.m10;
    assign tick_1hz  = tick;
    assign alarm_hit = alarm_hit_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper at CLK_HZ=4: reset, rollover, 12 h display, load
// validation, load/tick collision, alarm, pause and mid-count reset.
module tb_rtc_timekeeper;

    logic        clk = 1'b0;
    logic        resetn, run, mode_12h, load, alarm_en;
    logic [23:0] load_time;
    logic [15:0] alarm_time;
    logic [3:0]  cnt_sec1, cnt_sec10, cnt_min1, cnt_min10, cnt_hour1, cnt_hour10;
    logic        pm, tick_1hz, alarm_hit, load_err;
    logic [23:0] disp;

    int checks = 0;
    int errors = 0;

    rtc_timekeeper #(.CLK_HZ(4), .RST_H(8'h23), .RST_M(8'h59), .RST_S(8'h59)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .run        (run),
        .mode_12h   (mode_12h),
        .load       (load),
        .load_time  (load_time),
        .alarm_en   (alarm_en),
        .alarm_time (alarm_time),
        .cnt_sec1   (cnt_sec1),
        .cnt_sec10  (cnt_sec10),
        .cnt_min1   (cnt_min1),
        .cnt_min10  (cnt_min10),
        .cnt_hour1  (cnt_hour1),
        .cnt_hour10 (cnt_hour10),
        .pm         (pm),
        .tick_1hz   (tick_1hz),
        .alarm_hit  (alarm_hit),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    assign disp = {cnt_hour10, cnt_hour1, cnt_min10, cnt_min1, cnt_sec10, cnt_sec1};

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 2 time units after the edge.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; run = 1'b0; mode_12h = 1'b0; load = 1'b0;
        load_time = 24'h0; alarm_en = 1'b0; alarm_time = 16'h0;
        cyc(2);
        check("rst_time", disp, 24'h235959);
        check("rst_tick", 24'(tick_1hz), 24'h0);
        check("rst_alarm", 24'(alarm_hit), 24'h0);
        check("rst_err", 24'(load_err), 24'h0);

        // 1: first tick in the 4th running cycle, then midnight rollover
        resetn = 1'b1; run = 1'b1; #1;
        check("t1_pm", 24'(pm), 24'h1);
        check("t1_tick_c0", 24'(tick_1hz), 24'h0);
        cyc(2);
        check("t1_tick_c2", 24'(tick_1hz), 24'h0);
        cyc(1);
        check("t1_tick_c3", 24'(tick_1hz), 24'h1);
        check("t1_hold", disp, 24'h235959);
        cyc(1);
        check("t1_roll", disp, 24'h000000);
        check("t1_pm0", 24'(pm), 24'h0);
        check("t1_tick_after", 24'(tick_1hz), 24'h0);

        // 2: 12 h display, 00 -> 12, 12:59:59 -> 13:00:00 shown as 01
        mode_12h = 1'b1; #1;
        check("t2_midnight12", disp, 24'h120000);
        load = 1'b1; load_time = 24'h125959; #1;
        check("t2_load_notick", 24'(tick_1hz), 24'h0);
        cyc(1);
        load = 1'b0;
        check("t2_noon12", disp, 24'h125959);
        check("t2_noon_pm", 24'(pm), 24'h1);
        check("t2_noerr", 24'(load_err), 24'h0);
        cyc(3);
        check("t2_tick", 24'(tick_1hz), 24'h1);
        cyc(1);
        check("t2_13h_12", disp, 24'h010000);
        check("t2_13h_pm", 24'(pm), 24'h1);
        mode_12h = 1'b0; #1;
        check("t2_13h_24", disp, 24'h130000);

        // 3: invalid loads flag an error and leave time and prescaler alone
        load = 1'b1; load_time = 24'h240000;
        cyc(1);
        check("t3_err_hour", 24'(load_err), 24'h1);
        check("t3_time_a", disp, 24'h130000);
        load_time = 24'h0A0000;
        cyc(1);
        check("t3_err_digit", 24'(load_err), 24'h1);
        check("t3_time_b", disp, 24'h130000);
        load = 1'b0;
        cyc(1);
        check("t3_err_clear", 24'(load_err), 24'h0);
        check("t3_tick_kept", 24'(tick_1hz), 24'h1);
        cyc(1);
        check("t3_adv", disp, 24'h130001);

        // 4: valid load on the tick cycle wins, next tick 4 cycles later
        cyc(3);
        check("t4_tick_pre", 24'(tick_1hz), 24'h1);
        load = 1'b1; load_time = 24'h065959; #1;
        check("t4_tick_supp", 24'(tick_1hz), 24'h0);
        cyc(1);
        load = 1'b0;
        check("t4_loaded", disp, 24'h065959);

        // 5: alarm at 07:00
        alarm_time = 16'h0700; alarm_en = 1'b1;
        cyc(2);
        check("t4_tick_c2", 24'(tick_1hz), 24'h0);
        cyc(1);
        check("t4_tick_c3", 24'(tick_1hz), 24'h1);
        check("t5_alarm_pre", 24'(alarm_hit), 24'h0);
        cyc(1);
        check("t5_time", disp, 24'h070000);
        check("t5_alarm", 24'(alarm_hit), 24'h1);
        cyc(1);
        check("t5_alarm_1cyc", 24'(alarm_hit), 24'h0);
        load = 1'b1; load_time = 24'h065959;
        cyc(1);
        load = 1'b0; alarm_en = 1'b0;
        cyc(4);
        check("t5_dis_time", disp, 24'h070000);
        check("t5_dis_alarm", 24'(alarm_hit), 24'h0);
        alarm_en = 1'b1; load = 1'b1; load_time = 24'h070000;
        cyc(1);
        load = 1'b0;
        check("t5_load_noalarm", 24'(alarm_hit), 24'h0);

        // 6: pause freezes everything, then reset mid-count
        run = 1'b0; alarm_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("t6_pause_tick", 24'(tick_1hz), 24'h0);
        end
        check("t6_frozen", disp, 24'h070000);
        run = 1'b1;
        cyc(2);
        check("t6_resume_c2", 24'(tick_1hz), 24'h0);
        cyc(1);
        check("t6_resume_c3", 24'(tick_1hz), 24'h1);
        cyc(2);
        check("t6_adv", disp, 24'h070001);
        resetn = 1'b0;
        cyc(1);
        check("t6_rst_time", disp, 24'h235959);
        check("t6_rst_tick", 24'(tick_1hz), 24'h0);
        resetn = 1'b1;
        cyc(2);
        check("t6_rst_c2", 24'(tick_1hz), 24'h0);
        cyc(1);
        check("t6_rst_c3", 24'(tick_1hz), 24'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
